cdb_arbiter: RTL and testbench

Arbitrates the single common data bus (CDB) of the out-of-order core among functional-unit result producers: add/ALU, multiply, divide and load. It grants one result per cycle using round-robin priority. The granted result is registered and broadcast on the next cycle to the reservation stations, the physical register file and the ROB.

---
 rtl/rv32i_types.sv | 30 +++
 rtl/rr_grant.sv | 42 ++++
 rtl/cdb_arbiter.sv | 66 ++++++
 tb/tb_cdb_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_types (package)
// Brief    : Shared core types; holds the CDB broadcast packet and the
//            constants used by the result-bus arbiter.
// Revision : 1.0 - initial CDB types
// ============================================================================
package rv32i_types;

  // Register-name widths, shared with the ROB output record
  localparam int c_PHYS_REG_W = 6;
  localparam int c_ARCH_REG_W = 5;

  localparam int NUM_CDB_REQ = 4;
  localparam int ROB_IDX_W   = 5;

  typedef struct packed {
    logic [c_PHYS_REG_W-1:0] pd;
    logic [c_ARCH_REG_W-1:0] rd;
    logic [ROB_IDX_W-1:0]    rob;
    logic [31:0]             value;
  } cdb_pkt_t;

  // Index that follows idx in a ring of n entries
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_grant.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant
// Brief    : Combinational rotate-priority encoder. The request at index ptr
//            has top priority, then ptr+1, ... wrapping modulo N.
// Revision : 1.0 - initial version
// ============================================================================
module rr_grant
  import rv32i_types::*;
#(
  parameter int N     = NUM_CDB_REQ,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any_gnt
);

  logic [PTR_W-1:0] w_cand;

  // Scan from the lowest priority to the highest so the last hit wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    w_cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = PTR_W'((int'(ptr) + k) % N);
      if (req[w_cand]) begin
        gnt_idx = w_cand;
        any_gnt = 1'b1;
      end
    end
    if (any_gnt) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Round-robin arbiter for the common data bus. Grants one result
//            producer per cycle and broadcasts the granted packet from a
//            register one cycle later.
// Revision : 1.0 - initial version
// ============================================================================
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_REQ = NUM_CDB_REQ
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  cdb_pkt_t [NUM_REQ-1:0] req_pkt,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   cdb_valid,
  output cdb_pkt_t               cdb_pkt
);

  localparam int c_PTR_W = $clog2(NUM_REQ);

  logic [c_PTR_W-1:0] r_rr_ptr;
  logic [c_PTR_W-1:0] w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_any_gnt;
  logic               w_block;
  logic               w_xfer;

  rr_grant #(
    .N     (NUM_REQ),
    .PTR_W (c_PTR_W)
  ) u_rr_grant (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any_gnt (w_any_gnt)
  );

  // Reset and flush both suppress the grant; the encoder only ever picks a
  // valid requester, so any unsuppressed grant is a transfer.
  assign w_block   = rst | flush;
  assign req_ready = w_block ? '0 : w_gnt;
  assign w_xfer    = w_any_gnt & ~w_block;

  // Broadcast register and priority pointer; payload holds when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_pkt   <= '0;
      r_rr_ptr  <= '0;
    end else if (w_xfer) begin
      cdb_valid <= 1'b1;
      cdb_pkt   <= req_pkt[w_gnt_idx];
      r_rr_ptr  <= c_PTR_W'(rr_next(int'(w_gnt_idx), NUM_REQ));
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Self-checking bench for cdb_arbiter: directed vector table plus
//            a random hold-until-granted traffic run, with a packet queue
//            predicting each broadcast.
// Revision : 1.0 - initial version
// ============================================================================
module tb_cdb_arbiter;
  import rv32i_types::*;

  logic           clk;
  logic           rst;
  logic           flush;
  logic [3:0]     req_valid;
  cdb_pkt_t [3:0] req_pkt;
  logic [3:0]     req_ready;
  logic           cdb_valid;
  cdb_pkt_t       cdb_pkt;

  int checks = 0;
  int errors = 0;

  cdb_pkt_t exp_q[$];
  cdb_pkt_t hold_pkt = '0;

  typedef struct {
    logic [3:0] valid;
    logic       flush;
    logic       rst;
    logic [3:0] exp_ready;
    logic [1:0] exp_ptr;
  } vec_t;

  vec_t tbl[23];

  cdb_arbiter #(.NUM_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_pkt   (req_pkt),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_pkt   (cdb_pkt)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive, check the grant mid-cycle, check the broadcast after the edge
  task automatic step(input logic [3:0] v, input logic f, input logic r,
                      input logic [3:0] er, input logic [1:0] ep);
    req_valid = v;
    flush     = f;
    rst       = r;
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(er));
    for (int i = 0; i < 4; i++) begin
      if (er[i]) exp_q.push_back(req_pkt[i]);
    end
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      hold_pkt = '0;
      chk("cdb_valid", 64'(cdb_valid), 64'(0));
    end else if (exp_q.size() > 0) begin
      hold_pkt = exp_q.pop_front();
      chk("cdb_valid", 64'(cdb_valid), 64'(1));
    end else begin
      chk("cdb_valid", 64'(cdb_valid), 64'(0));
    end
    chk("cdb_pkt", 64'(cdb_pkt), 64'(hold_pkt));
    chk("rr_ptr", 64'(dut.r_rr_ptr), 64'(ep));
  endtask

  initial begin
    logic [3:0] pend;
    logic [3:0] er;
    logic [1:0] m_ptr;
    logic [63:0] rnd;
    int g;
    int idx;

    req_valid = '0;
    flush     = 1'b0;
    rst       = 1'b1;
    req_pkt[0] = '{pd: 6'd0,  rd: 5'd0, rob: 5'd3,  value: 32'h1234_5678};
    req_pkt[1] = '{pd: 6'd33, rd: 5'd7, rob: 5'd14, value: 32'hCAFE_0001};
    req_pkt[2] = '{pd: 6'd17, rd: 5'd5, rob: 5'd9,  value: 32'hDEAD_BEEF};
    req_pkt[3] = '{pd: 6'd62, rd: 5'd31, rob: 5'd30, value: 32'h0BAD_F00D};

    //            valid  flush rst   ready  ptr-after
    tbl[0]  = '{4'hF, 1'b0, 1'b1, 4'h0, 2'd0};   // reset, all requesting
    tbl[1]  = '{4'hF, 1'b0, 1'b1, 4'h0, 2'd0};
    tbl[2]  = '{4'hF, 1'b0, 1'b0, 4'h1, 2'd1};   // contention 0,1,2,3,0
    tbl[3]  = '{4'hF, 1'b0, 1'b0, 4'h2, 2'd2};
    tbl[4]  = '{4'hF, 1'b0, 1'b0, 4'h4, 2'd3};
    tbl[5]  = '{4'hF, 1'b0, 1'b0, 4'h8, 2'd0};   // wrap
    tbl[6]  = '{4'hF, 1'b0, 1'b0, 4'h1, 2'd1};
    tbl[7]  = '{4'h4, 1'b0, 1'b0, 4'h4, 2'd3};   // single request at 2
    tbl[8]  = '{4'hA, 1'b0, 1'b0, 4'h8, 2'd0};   // rotation from 3
    tbl[9]  = '{4'h2, 1'b0, 1'b0, 4'h2, 2'd2};
    tbl[10] = '{4'h0, 1'b0, 1'b0, 4'h0, 2'd2};   // idle, payload holds
    tbl[11] = '{4'h1, 1'b1, 1'b0, 4'h0, 2'd2};   // flush blocks grant
    tbl[12] = '{4'h1, 1'b0, 1'b0, 4'h1, 2'd1};   // pd=0 broadcast unchanged
    tbl[13] = '{4'h1, 1'b0, 1'b0, 4'h1, 2'd1};   // lone requester twice
    tbl[14] = '{4'h6, 1'b0, 1'b0, 4'h2, 2'd2};
    tbl[15] = '{4'h4, 1'b0, 1'b0, 4'h4, 2'd3};   // grant to 2
    tbl[16] = '{4'h8, 1'b0, 1'b1, 4'h0, 2'd0};   // reset mid-stream
    tbl[17] = '{4'h9, 1'b0, 1'b0, 4'h1, 2'd1};   // re-arbitrate from 0
    tbl[18] = '{4'h8, 1'b0, 1'b0, 4'h8, 2'd0};
    tbl[19] = '{4'h0, 1'b0, 1'b0, 4'h0, 2'd0};
    tbl[20] = '{4'hF, 1'b1, 1'b1, 4'h0, 2'd0};   // reset and flush together
    tbl[21] = '{4'hF, 1'b1, 1'b0, 4'h0, 2'd0};
    tbl[22] = '{4'h2, 1'b0, 1'b0, 4'h2, 2'd2};

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].valid, tbl[i].flush, tbl[i].rst, tbl[i].exp_ready, tbl[i].exp_ptr);
    end

    // Random traffic: producers raise requests at will and hold them until granted
    pend  = '0;
    m_ptr = tbl[22].exp_ptr;
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]    = 1'b1;
          rnd        = {$urandom, $urandom};
          req_pkt[i] = rnd[47:0];
        end
      end
      er = '0;
      g  = -1;
      for (int k = 0; k < 4; k++) begin
        idx = (int'(m_ptr) + k) % 4;
        if (pend[idx] && g < 0) g = idx;
      end
      if (g >= 0) begin
        er[g] = 1'b1;
        m_ptr = 2'((g + 1) % 4);
      end
      step(pend, 1'b0, 1'b0, er, m_ptr);
      pend = pend & ~er;
    end

    req_valid = '0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
